red_pitaya_na_accumulator: RTL and testbench

Multi-channel network-analyzer averaging engine that replaces the single-pair I/Q sum logic inside the IQ block. It accumulates CHANNELS signed demodulated quadratures over a programmable window after a programmable settling delay. It adds:
- a sample-valid qualifier
- per-channel saturating sums with sticky overflow flags
- abort
- continuous re-arm mode
- a result snapshot register, so software reads stable data while the next window runs

---
 rtl/red_pitaya_na_accumulator.sv | 194 +++++++++++++++++++
 tb/tb_red_pitaya_na_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_na_accumulator.sv
// rtl/red_pitaya_na_accumulator.sv - multi-channel network-analyzer averaging engine
//
// Purpose:
//   Accumulates CHANNELS signed demodulated quadratures over a programmable
//   number of valid samples, after a programmable settling delay. Each channel
//   has a saturating accumulator with a sticky overflow flag. A completed run is
//   copied into a snapshot register so software reads stable data while the
//   next window (continuous mode) is already accumulating.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, abort_i      single-cycle control pulses (abort wins)
//   cont_i                continuous re-arm after each completed run
//   averages_i            valid samples per run (sampled at start)
//   sleepcycles_i         settling cycles before accumulation (sampled at start)
//   dat_i, valid_i        packed signed samples, channel k at [k*INBITS +: INBITS]
//   state_o               IDLE=0, SLEEP=1, AVERAGE=2, DONE=3
//   busy_o                SLEEP or AVERAGE, decoded from the state register
//   done_o                one-cycle pulse on entry to DONE
//   result_valid_o        result_o holds a completed run
//   result_o              snapshot of the sums, same packing as dat_i
//   overflow_o            sticky per-channel saturation flags of the current run
//   seq_o                 completed-run counter, wraps

module red_pitaya_na_accumulator #(
    parameter int CHANNELS = 2,
    parameter int INBITS   = 24,
    parameter int SUMBITS  = 62,
    parameter int CNTBITS  = 32,
    parameter int SEQBITS  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic                         cont_i,
    input  logic [CNTBITS-1:0]           averages_i,
    input  logic [CNTBITS-1:0]           sleepcycles_i,
    input  logic [CHANNELS*INBITS-1:0]   dat_i,
    input  logic                         valid_i,
    output logic [1:0]                   state_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         result_valid_o,
    output logic [CHANNELS*SUMBITS-1:0]  result_o,
    output logic [CHANNELS-1:0]          overflow_o,
    output logic [SEQBITS-1:0]           seq_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SLEEP   = 2'd1,
        ST_AVERAGE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [CNTBITS-1:0]            sleep_cnt_q, sleep_cnt_d;
    logic [CNTBITS-1:0]            avg_cnt_q, avg_cnt_d;
    logic [CHANNELS*SUMBITS-1:0]   acc_q, acc_d;
    logic [CHANNELS-1:0]           ovf_q, ovf_d;
    logic [CHANNELS*SUMBITS-1:0]   result_q;
    logic                          result_valid_q;
    logic                          done_q;
    logic [SEQBITS-1:0]            seq_q;

    // Per-cycle control decoded by the next-state logic.
    logic                          enter_done;
    logic                          explicit_start;

    // Saturated next sums for every channel, assuming the sample is taken.
    logic [CHANNELS*SUMBITS-1:0]   sum_sat;
    logic [CHANNELS-1:0]           sum_ovf;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic signed [SUMBITS-1:0] acc_k;
        logic signed [INBITS-1:0]  dat_k;
        logic signed [SUMBITS:0]   wide_k;
        logic                      sat_hi;
        logic                      sat_lo;

        assign acc_k  = acc_q[k*SUMBITS +: SUMBITS];
        assign dat_k  = dat_i[k*INBITS +: INBITS];
        // One guard bit is enough: the sum of two in-range values cannot
        // exceed the SUMBITS+1 range, and the top two bits disagree exactly
        // when the result left the SUMBITS range.
        assign wide_k = {acc_k[SUMBITS-1], acc_k}
                      + {{(SUMBITS+1-INBITS){dat_k[INBITS-1]}}, dat_k};
        assign sat_hi = ~wide_k[SUMBITS] &  wide_k[SUMBITS-1];
        assign sat_lo =  wide_k[SUMBITS] & ~wide_k[SUMBITS-1];

        assign sum_sat[k*SUMBITS +: SUMBITS] =
            sat_hi ? {1'b0, {(SUMBITS-1){1'b1}}} :
            sat_lo ? {1'b1, {(SUMBITS-1){1'b0}}} :
                     wide_k[SUMBITS-1:0];
        assign sum_ovf[k] = sat_hi | sat_lo;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d        = state_q;
        sleep_cnt_d    = sleep_cnt_q;
        avg_cnt_d      = avg_cnt_q;
        acc_d          = acc_q;
        ovf_d          = ovf_q;
        enter_done     = 1'b0;
        explicit_start = 1'b0;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else if (start_i || (state_q == ST_DONE && cont_i)) begin
            // Explicit or implicit start: both reload from the live inputs,
            // only the explicit one invalidates the snapshot.
            explicit_start = start_i;
            sleep_cnt_d    = sleepcycles_i;
            avg_cnt_d      = averages_i;
            acc_d          = '0;
            ovf_d          = '0;
            if (sleepcycles_i != '0) begin
                state_d = ST_SLEEP;
            end else if (averages_i != '0) begin
                state_d = ST_AVERAGE;
            end else begin
                state_d    = ST_DONE;
                enter_done = 1'b1;
            end
        end else begin
            case (state_q)
                ST_SLEEP: begin
                    sleep_cnt_d = sleep_cnt_q - CNTBITS'(1);
                    if (sleep_cnt_q == CNTBITS'(1)) begin
                        if (avg_cnt_q != '0) begin
                            state_d = ST_AVERAGE;
                        end else begin
                            state_d    = ST_DONE;
                            enter_done = 1'b1;
                        end
                    end
                end
                ST_AVERAGE: begin
                    if (valid_i) begin
                        acc_d     = sum_sat;
                        ovf_d     = ovf_q | sum_ovf;
                        avg_cnt_d = avg_cnt_q - CNTBITS'(1);
                        if (avg_cnt_q == CNTBITS'(1)) begin
                            state_d    = ST_DONE;
                            enter_done = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            sleep_cnt_q    <= '0;
            avg_cnt_q      <= '0;
            acc_q          <= '0;
            ovf_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            seq_q          <= '0;
        end else begin
            state_q     <= state_d;
            sleep_cnt_q <= sleep_cnt_d;
            avg_cnt_q   <= avg_cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            done_q      <= enter_done;
            // The snapshot takes the post-update sums so the last sample of
            // the window is included in the cycle right after it is taken.
            if (enter_done) begin
                result_q       <= acc_d;
                result_valid_q <= 1'b1;
                seq_q          <= seq_q + SEQBITS'(1);
            end else if (explicit_start) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign state_o        = state_q;
    assign busy_o         = (state_q == ST_SLEEP) || (state_q == ST_AVERAGE);
    assign done_o         = done_q;
    assign result_valid_o = result_valid_q;
    assign result_o       = result_q;
    assign overflow_o     = ovf_q;
    assign seq_o          = seq_q;

endmodule

// File: tb/tb_red_pitaya_na_accumulator.sv
// tb/tb_red_pitaya_na_accumulator.sv - directed self-checking bench for red_pitaya_na_accumulator

module tb_red_pitaya_na_accumulator;

    localparam int CH  = 2;
    localparam int IB  = 24;
    localparam int SB  = 26;
    localparam int CB  = 32;
    localparam int QB  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              cont;
    logic [CB-1:0]     averages;
    logic [CB-1:0]     sleepcycles;
    logic [CH*IB-1:0]  dat;
    logic              valid;
    logic [1:0]        state;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic [CH*SB-1:0]  result;
    logic [CH-1:0]     overflow;
    logic [QB-1:0]     seq;

    int checks = 0;
    int errors = 0;

    red_pitaya_na_accumulator #(
        .CHANNELS(CH), .INBITS(IB), .SUMBITS(SB), .CNTBITS(CB), .SEQBITS(QB)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .cont_i(cont),
        .averages_i(averages), .sleepcycles_i(sleepcycles), .dat_i(dat),
        .valid_i(valid), .state_o(state), .busy_o(busy), .done_o(done),
        .result_valid_o(result_valid), .result_o(result), .overflow_o(overflow),
        .seq_o(seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] res(input int k);
        logic signed [SB-1:0] t;
        t = result[k*SB +: SB];
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dat(input int c0, input int c1);
        dat = {c1[IB-1:0], c0[IB-1:0]};
    endtask

    task automatic pulse_start(input int s, input int a);
        sleepcycles = s;
        averages    = a;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Counts consecutive observed cycles in state st, bounded.
    task automatic count_state(input logic [1:0] st, output int n);
        n = 0;
        while (state == st && n < 200) begin
            n++;
            tick();
        end
    endtask

    int n;
    int pat_v [6] = '{1, 0, 0, 1, 0, 1};
    int pat_d [6] = '{10, 99, 99, 20, 99, 30};

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; valid = 1'b0;
        averages = '0; sleepcycles = '0; set_dat(0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rvalid", result_valid, 0);
        check("rst_result0", res(0), 0);
        check("rst_ovf", overflow, 0);
        check("rst_seq", seq, 0);

        // 1: basic run
        valid = 1'b1; set_dat(5, -7);
        pulse_start(3, 4);
        check("t1_busy", busy, 1);
        count_state(2'd1, n);
        check("t1_sleep_cycles", n, 3);
        count_state(2'd2, n);
        check("t1_avg_cycles", n, 4);
        check("t1_state_done", state, 3);
        check("t1_done_pulse", done, 1);
        check("t1_ch0", res(0), 20);
        check("t1_ch1", res(1), -28);
        check("t1_seq", seq, 1);
        check("t1_rvalid", result_valid, 1);
        tick();
        check("t1_done_once", done, 0);
        check("t1_hold_done", state, 3);

        // 2: valid gating
        set_dat(0, 0);
        pulse_start(0, 3);
        check("t2_state_avg", state, 2);
        check("t2_rvalid_clr", result_valid, 0);
        for (int i = 0; i < 6; i++) begin
            valid = pat_v[i][0];
            set_dat(pat_d[i], 0);
            tick();
            if (i == 4) check("t2_still_avg", state, 2);
        end
        check("t2_state_done", state, 3);
        check("t2_ch0", res(0), 60);
        check("t2_seq", seq, 2);

        // 3: saturation high, then low after a fresh start
        valid = 1'b1; set_dat(8388607, 0);
        pulse_start(0, 8);
        for (int i = 0; i < 8; i++) tick();
        check("t3_state_done", state, 3);
        check("t3_ch0_sat", res(0), 33554431);
        check("t3_ch1", res(1), 0);
        check("t3_ovf", overflow, 2'b01);
        set_dat(-8388608, 0);
        pulse_start(0, 8);
        check("t3_ovf_clr", overflow, 0);
        for (int i = 0; i < 8; i++) tick();
        check("t3_ch0_neg_sat", res(0), -33554432);
        check("t3_ovf_neg", overflow, 2'b01);

        // 4: zero windows
        set_dat(3, 3);
        pulse_start(5, 0);
        count_state(2'd1, n);
        check("t4_sleep_cycles", n, 5);
        check("t4_done_after_sleep", state, 3);
        check("t4_done_pulse", done, 1);
        check("t4_ch0_zero", res(0), 0);
        check("t4_ovf_zero", overflow, 0);
        set_dat(1, 1);
        pulse_start(0, 2);
        check("t4_avg_next", state, 2);
        tick(); tick();
        check("t4_ch1", res(1), 2);
        check("t4_seq", seq, 6);

        // 5: continuous mode; DONE cycle sample (3) is not accumulated
        cont = 1'b1; set_dat(100, 0);
        pulse_start(0, 2);
        set_dat(1, 0); tick();
        set_dat(2, 0); tick();
        check("t5_run1", res(0), 3);
        check("t5_seq1", seq, 7);
        check("t5_state_done", state, 3);
        set_dat(3, 0); tick();
        check("t5_restart_avg", state, 2);
        check("t5_rvalid_hold", result_valid, 1);
        set_dat(4, 0); tick();
        check("t5_rvalid_mid", result_valid, 1);
        set_dat(5, 0); tick();
        check("t5_run2", res(0), 9);
        check("t5_seq2", seq, 8);
        set_dat(6, 0); tick();
        set_dat(7, 0); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        cont = 1'b0;
        check("t5_abort_idle", state, 0);
        check("t5_abort_result", res(0), 9);
        check("t5_abort_rvalid", result_valid, 1);

        // 6: priority, restart, async reset
        averages = 2; start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        check("t6_start_abort", state, 0);
        set_dat(1000, 0);
        pulse_start(0, 3);
        tick(); tick();
        pulse_start(0, 3);
        check("t6_restart_avg", state, 2);
        check("t6_result_kept", res(0), 9);
        set_dat(1, 0);
        for (int i = 0; i < 3; i++) tick();
        check("t6_fresh_sum", res(0), 3);
        pulse_start(0, 3);
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_async_state", state, 0);
        check("t6_async_result", res(0), 0);
        check("t6_async_seq", seq, 0);
        tick();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
